// File: rtl/compr42_seq_pkg.sv
// Shared state encoding, default width and carry realignment helper for the
// 4:2 compressor accumulation sequencer.
package compr42_seq_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

  // Compressor carry bit i has weight 2^(i+1); shift into place and drop the
  // MSB so the accumulator stays mod 2^W.
  function automatic logic [W_DEF-1:0] realign_carry(input logic [W_DEF-1:0] c);
    return {c[W_DEF-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/compr42_seq_cpa.sv
// Registered carry-propagate adder that resolves the redundant sum/carry pair
// into the final W-bit result; the carry-out is dropped.
module compr42_seq_cpa
  import compr42_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (load) begin
      sum <= a + b;
    end
  end

endmodule

// File: rtl/compr42_accum_seq.sv
// Time-multiplexes one external 4:2 compressor to reduce a stream of addends,
// then resolves the redundant accumulator and hands back the mod-2^W sum.
// Optional beat counter output enabled by defining COMPR42_SEQ_BEAT_CNT_EN.
module compr42_accum_seq
  import compr42_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_b_en,
  input  logic             in_last,
  input  logic             clr,
  output logic [W-1:0]     cmp_in1,
  output logic [W-1:0]     cmp_in2,
  output logic [W-1:0]     cmp_in3,
  output logic [W-1:0]     cmp_in4,
  input  logic [W-1:0]     cmp_c,
  input  logic [W-1:0]     cmp_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum
`ifdef COMPR42_SEQ_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  state_t       state;
  logic [W-1:0] acc_s;
  logic [W-1:0] acc_c;
  logic         accept;
  logic         handshake;

  // clr wins over a beat presented on the same cycle.
  assign accept    = in_valid && in_ready && !clr;
  assign handshake = out_valid && out_ready;

  assign cmp_in1 = acc_s;
  assign cmp_in2 = acc_c;
  assign cmp_in3 = in_a;
  assign cmp_in4 = in_b_en ? in_b : '0;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc_s     <= '0;
      acc_c     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      acc_s     <= '0;
      acc_c     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= !(accept && in_last);
          if (accept) begin
            acc_s <= cmp_s;
            acc_c <= realign_carry(cmp_c);
            state <= in_last ? RESOLVE : ACCUM;
          end
        end
        RESOLVE: begin
          acc_s <= '0;
          acc_c <= '0;
          state <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle into DONE and holds until taken.
          if (handshake) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  compr42_seq_cpa #(
    .W(W)
  ) u_cpa (
    .clk (clk),
    .rst (rst),
    .load(state == RESOLVE && !clr),
    .a   (acc_s),
    .b   (acc_c),
    .sum (out_sum)
  );

`ifdef COMPR42_SEQ_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      beat_cnt <= '0;
    end else if (clr) begin
      cnt      <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        if (in_last) begin
          cnt      <= '0;
          beat_cnt <= cnt_inc;
        end else begin
          cnt <= cnt_inc;
        end
      end
      if (state == DONE && handshake) begin
        beat_cnt <= '0;
      end
    end
  end
`endif

endmodule
